// File: rtl/branch_predictor.sv
// Conditional-branch predictor: PHT of 2-bit saturating counters, trained at execute.
// Define BRANCH_PREDICTOR_GSHARE_EN for gshare indexing with speculative/committed GHR; default is bimodal.
module branch_predictor #(
  parameter int PHT_IDX_W = 10,
  parameter int GHR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcD,
  input  logic        branchD,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        stallE,
  input  logic        flushE,
  input  logic        branch_takeE,
  output logic        pred_takeD,
  output logic        pred_takeE,
  output logic        mispredictE
);

  localparam int PHT_SIZE = 1 << PHT_IDX_W;

  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_STRONG_NT = 2'b00;
  localparam ctr_t CTR_WEAK_NT   = 2'b01;
  localparam ctr_t CTR_STRONG_T  = 2'b11;

  function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
    ctr_t nxt;
    nxt = cur;
    if (taken && cur != CTR_STRONG_T)
      nxt = cur + 2'd1;
    else if (!taken && cur != CTR_STRONG_NT)
      nxt = cur - 2'd1;
    return nxt;
  endfunction

  ctr_t                 pht [PHT_SIZE];
  logic [PHT_IDX_W-1:0] pc_idx;
  logic [PHT_IDX_W-1:0] idx_d;
  logic [PHT_IDX_W-1:0] idx_e;
  logic                 valid_e;
  logic                 pred_e;
  logic                 resolve;

  assign pc_idx = pcD[PHT_IDX_W+1:2];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [GHR_WIDTH-1:0] spec_ghr;
  logic [GHR_WIDTH-1:0] commit_ghr;
  logic [GHR_WIDTH-1:0] repair_ghr;
  logic [PHT_IDX_W-1:0] ghr_ext;
  logic                 unused_inputs;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ghr_ext                = '0;
    ghr_ext[GHR_WIDTH-1:0] = spec_ghr;
  end

  assign idx_d      = pc_idx ^ ghr_ext;
  assign repair_ghr = {commit_ghr[GHR_WIDTH-2:0], branch_takeE};

  // A resolving mispredict rebuilds history from the committed copy; the
  // redirect squashes decode, so a same-cycle decode shift is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      spec_ghr   <= '0;
      commit_ghr <= '0;
    end else begin
      if (resolve)
        commit_ghr <= repair_ghr;
      if (resolve && mispredictE)
        spec_ghr <= repair_ghr;
      else if (branchD && !stallD && !flushD)
        spec_ghr <= {spec_ghr[GHR_WIDTH-2:0], pred_takeD};
    end
  end

  assign unused_inputs = ^{pcD[31:PHT_IDX_W+2], pcD[1:0]};
`else
  logic unused_inputs;

  assign idx_d         = pc_idx;
  assign unused_inputs = ^{pcD[31:PHT_IDX_W+2], pcD[1:0], stallD};
`endif

  assign pred_takeD  = branchD & pht[idx_d][1];
  assign pred_takeE  = pred_e & valid_e;
  assign mispredictE = valid_e & (pred_e != branch_takeE);
  assign resolve     = valid_e & ~stallE;

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_e <= 1'b0;
      idx_e   <= '0;
      pred_e  <= 1'b0;
    end else if (flushE) begin
      valid_e <= 1'b0;
    end else if (!stallE) begin
      valid_e <= branchD & ~flushD;
      idx_e   <= idx_d;
      pred_e  <= pred_takeD;
    end
  end

  // NOTE: the table must reset to weak-NT, so it is built from flops rather than a RAM macro.
  // Reset wins over a same-cycle resolve, discarding the in-flight branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_SIZE; i++)
        pht[i] <= CTR_WEAK_NT;
    end else if (resolve) begin
      pht[idx_e] <= ctr_next(pht[idx_e], branch_takeE);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (bimodal by default, gshare sequence when the macro is set).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcD;
  logic        branchD;
  logic        stallD;
  logic        flushD;
  logic        stallE;
  logic        flushE;
  logic        branch_takeE;
  logic        pred_takeD;
  logic        pred_takeE;
  logic        mispredictE;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] PC_A = 32'h0040_0010;  // PHT index 4
  localparam logic [31:0] PC_Z = 32'h0000_0000;  // PHT index 0

  branch_predictor dut (
    .clk          (clk),
    .rst          (rst),
    .pcD          (pcD),
    .branchD      (branchD),
    .stallD       (stallD),
    .flushD       (flushD),
    .stallE       (stallE),
    .flushE       (flushE),
    .branch_takeE (branch_takeE),
    .pred_takeD   (pred_takeD),
    .pred_takeE   (pred_takeE),
    .mispredictE  (mispredictE)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated branch: lookup in D, then resolve in E with the given outcome.
  task automatic run_branch(input string tag, input logic [31:0] pc, input logic take,
                            input logic exp_pred, input logic exp_mis);
    branchD = 1'b1;
    pcD     = pc;
    #1;
    check({tag, "_predD"}, 8'(pred_takeD), 8'(exp_pred));
    tick();
    branchD      = 1'b0;
    branch_takeE = take;
    #1;
    check({tag, "_predE"}, 8'(pred_takeE), 8'(exp_pred));
    check({tag, "_misE"}, 8'(mispredictE), 8'(exp_mis));
    tick();
    branch_takeE = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; pcD = 32'h0; branchD = 1'b0; stallD = 1'b0; flushD = 1'b0;
    stallE = 1'b0; flushE = 1'b0; branch_takeE = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_pht_a",    8'(dut.pht[4]),    8'h01);
    check("rst_pht_last", 8'(dut.pht[1023]), 8'h01);
    check("rst_predD",    8'(pred_takeD),    8'h00);
    check("rst_predE",    8'(pred_takeE),    8'h00);
    check("rst_misE",     8'(mispredictE),   8'h00);

`ifndef BRANCH_PREDICTOR_GSHARE_EN
    // First branch after reset: predicted NT, resolved NT.
    branchD = 1'b1; pcD = PC_A;
    #1;
    check("t1_predD", 8'(pred_takeD), 8'h00);
    tick();
    branchD = 1'b0; branch_takeE = 1'b0;
    #1;
    check("t1_predE",    8'(pred_takeE),  8'h00);
    check("t1_misE",     8'(mispredictE), 8'h00);
    check("t1_pht_pre",  8'(dut.pht[4]),  8'h01);
    tick();
    check("t1_pht_post", 8'(dut.pht[4]),  8'h00);

    // Reset mid-operation restores weak-NT.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst2_pht_a", 8'(dut.pht[4]), 8'h01);

    // Back-to-back taken on the same PC; decode sees the pre-update counter.
    branchD = 1'b1; pcD = PC_A;
    tick();
    branch_takeE = 1'b1;
    #1;
    check("bb_misE1",     8'(mispredictE), 8'h01);
    check("bb_nobypass",  8'(pred_takeD),  8'h00);
    tick();
    #1;
    check("bb_pht_10",    8'(dut.pht[4]),  8'h02);
    check("bb_predD_10",  8'(pred_takeD),  8'h01);
    check("bb_misE2",     8'(mispredictE), 8'h01);
    branchD = 1'b0;
    tick();
    check("bb_pht_11",    8'(dut.pht[4]),  8'h03);
    check("bb_misE_idle", 8'(mispredictE), 8'h00);
    check("bb_nobranchD", 8'(pred_takeD),  8'h00);
    branch_takeE = 1'b0;

    // Three not-taken resolves walk 11 -> 10 -> 01 -> 00, then saturate.
    run_branch("nt1", PC_A, 1'b0, 1'b1, 1'b1);
    check("nt1_pht", 8'(dut.pht[4]), 8'h02);
    run_branch("nt2", PC_A, 1'b0, 1'b1, 1'b1);
    check("nt2_pht", 8'(dut.pht[4]), 8'h01);
    run_branch("nt3", PC_A, 1'b0, 1'b0, 1'b0);
    check("nt3_pht", 8'(dut.pht[4]), 8'h00);
    run_branch("nt4", PC_A, 1'b0, 1'b0, 1'b0);
    check("nt4_sat", 8'(dut.pht[4]), 8'h00);
    check("other_entry_untouched", 8'(dut.pht[5]), 8'h01);

    // Execute stall: mispredict held, single update when the stall drops.
    branchD = 1'b1; pcD = PC_A;
    tick();
    branchD = 1'b0; stallE = 1'b1; branch_takeE = 1'b1;
    #1;
    check("st_misE0", 8'(mispredictE), 8'h01);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_misE_hold", 8'(mispredictE), 8'h01);
      check("st_pht_hold",  8'(dut.pht[4]),  8'h00);
    end
    stallE = 1'b0;
    tick();
    check("st_pht_once", 8'(dut.pht[4]),  8'h01);
    check("st_misE_end", 8'(mispredictE), 8'h00);
    branch_takeE = 1'b0;

    // flushE bubbles the captured branch.
    branchD = 1'b1; pcD = PC_A; flushE = 1'b1;
    tick();
    flushE = 1'b0; branchD = 1'b0; branch_takeE = 1'b1;
    #1;
    check("fe_predE", 8'(pred_takeE),  8'h00);
    check("fe_misE",  8'(mispredictE), 8'h00);
    tick();
    check("fe_pht",   8'(dut.pht[4]),  8'h01);

    // flushD keeps the decode branch out of execute.
    branchD = 1'b1; flushD = 1'b1;
    tick();
    branchD = 1'b0; flushD = 1'b0;
    #1;
    check("fd_misE", 8'(mispredictE), 8'h00);
    tick();
    check("fd_pht",  8'(dut.pht[4]),  8'h01);
    branch_takeE = 1'b0;

    // Reset while a branch sits in execute: it must not train.
    branchD = 1'b1; pcD = PC_A;
    tick();
    branchD = 1'b0; branch_takeE = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; branch_takeE = 1'b0;
    #1;
    check("rst_inflight_pht",  8'(dut.pht[4]),  8'h01);
    check("rst_inflight_predE", 8'(pred_takeE), 8'h00);
`else
    // Gshare: mispredict repairs spec_ghr from commit_ghr; concurrent decode shift dropped.
    branchD = 1'b1; pcD = PC_A;
    #1;
    check("g_predD0", 8'(pred_takeD), 8'h00);
    tick();
    pcD = PC_Z; branch_takeE = 1'b1;
    #1;
    check("g_misE", 8'(mispredictE), 8'h01);
    tick();
    check("g_spec_repair", 8'(dut.spec_ghr),   8'h01);
    check("g_commit1",     8'(dut.commit_ghr), 8'h01);
    check("g_pht4",        8'(dut.pht[4]),     8'h02);
    branchD = 1'b0; branch_takeE = 1'b0;
    #1;
    check("g_misE_z", 8'(mispredictE), 8'h00);
    tick();
    check("g_commit2", 8'(dut.commit_ghr), 8'h02);
    check("g_spec1",   8'(dut.spec_ghr),   8'h01);
    check("g_pht0",    8'(dut.pht[0]),     8'h00);

    // Same PC under GHR 0x01 lands on index 5 and trains independently.
    run_branch("g_a_ghr1", PC_A, 1'b0, 1'b0, 1'b0);
    check("g_pht4_taken", 8'(dut.pht[4]),   8'h02);
    check("g_pht5_nt",    8'(dut.pht[5]),   8'h00);
    check("g_spec2",      8'(dut.spec_ghr), 8'h02);

    // flushD blocks the speculative shift.
    branchD = 1'b1; flushD = 1'b1;
    tick();
    branchD = 1'b0; flushD = 1'b0;
    check("g_flushD_spec", 8'(dut.spec_ghr), 8'h02);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
